// File: rtl/sort_engine.sv
// Frame sorter: loads up to DEPTH words, sorts them with odd-even transposition,
// then streams the N real words out in ascending or descending order.
module sort_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready,
    output logic             busy
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    last_q, last_d;
    logic [IW-1:0]    rd_q, rd_d;
    logic [SW-1:0]    step_q, step_d;
    logic             mode_q, mode_d;
    logic             accept;
    logic             pair_odd;
    logic             swap;

    assign in_ready  = (state_q == LOAD) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == OUT);
    assign out_data  = out_valid ? mem_q[rd_q] : '0;
    assign out_last  = out_valid && (rd_q == last_q);
    assign busy      = (state_q != LOAD);

    // Step 0 of SORT pads; step s>0 runs transposition phase s-1.
    assign pair_odd = ~step_q[0];

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        rd_d    = rd_q;
        step_d  = step_q;
        mode_d  = mode_q;
        swap    = 1'b0;
        unique case (state_q)
            LOAD: begin
                if (accept) begin
                    mem_d[cnt_q] = in_data;
                    if (cnt_q == '0) mode_d = mode;
                    if (in_last || (cnt_q == IW'(DEPTH - 1))) begin
                        last_d  = cnt_q;
                        cnt_d   = '0;
                        step_d  = '0;
                        state_d = SORT;
                    end else begin
                        cnt_d = cnt_q + IW'(1);
                    end
                end
            end
            SORT: begin
                if (step_q == '0) begin
                    // Padding sinks to the tail so only real words reach indices 0..N-1.
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        if (i > int'(last_q)) mem_d[i] = mode_q ? '0 : '1;
                    end
                end else begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        swap = mode_q ? (mem_q[i] < mem_q[i+1]) : (mem_q[i] > mem_q[i+1]);
                        if ((i[0] == pair_odd) && swap) begin
                            mem_d[i]   = mem_q[i+1];
                            mem_d[i+1] = mem_q[i];
                        end
                    end
                end
                step_d = step_q + SW'(1);
                if (step_q == SW'(DEPTH)) begin
                    state_d = OUT;
                    rd_d    = '0;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (rd_q == last_q) begin
                        state_d = LOAD;
                        rd_d    = '0;
                        cnt_d   = '0;
                    end else begin
                        rd_d = rd_q + IW'(1);
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LOAD;
            cnt_q   <= '0;
            last_q  <= '0;
            rd_q    <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            rd_q    <= rd_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= mem_d[i];
        end
    end

endmodule
